mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit implementing MIPS MULT, MULTU, DIV and DIVU, with architectural HI/LO registers.
- Sits directly downstream of the register file. Operands are the two register-file read ports (rs → rs_data, rt → rt_data).
- HI/LO outputs feed the MFHI/MFLO path back to the register file write-data mux.
- Also supports MTHI/MTLO writes. One operation in flight; multi-cycle start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  WIDTH  multiplicand / dividend (register-file ReadData1).
- rt_data  input  WIDTH  multiplier / divisor (register-file ReadData2).
- hi_we  input  1  MTHI: write wr_data into HI.
- lo_we  input  1  MTLO: write wr_data into LO.
- wr_data  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, at any time, including mid-operation): state returns to IDLE; hi, lo, the internal accumulators and the counter all go to 0; busy = 0, done = 0. The in-flight operation is discarded.
- State machine has four states: IDLE, PREP, RUN, FIX. busy = (state != IDLE).
- IDLE:
  - If start is high on an edge: latch op, rs_data and rt_data, then go to PREP.
  - Else if hi_we/lo_we is high: write wr_data to HI/LO (both may write in the same cycle).
  - start has priority. A hi_we/lo_we in the same cycle as an accepted start is dropped.
- PREP (1 cycle):
  - Signed ops: take absolute values of both operands and record the result signs.
  - Initialise the accumulator and set the counter to WIDTH-1.
- RUN (WIDTH cycles):
  - Multiply: one shift-add step per cycle on a 2×WIDTH product register.
  - Divide: one restoring subtract/shift step per cycle; partial remainder is WIDTH+1 bits.
  - Counter decrements each cycle; RUN exits to FIX after the step with counter == 0.
- FIX (1 cycle):
  - Apply sign correction and write HI/LO on the exit edge, then go to IDLE.
  - done is registered: high for exactly the one cycle after the FIX exit edge, the first cycle with the new hi/lo and busy = 0.
- Latency: start sampled on edge E → busy high for cycles E+1 … E+WIDTH+2 → done and the new hi/lo visible at E+WIDTH+3 (35 cycles for WIDTH = 32). The latency is fixed for every op and operand value.
- Multiply results: HI = upper WIDTH bits, LO = lower WIDTH bits of the full 2×WIDTH product. MULT treats operands as two's complement; MULTU as unsigned.
- Divide results: LO = quotient, HI = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (rt == 0, DIV or DIVU): LO = all-ones, HI = rs_data, with the same latency.
- Signed overflow (DIV of most-negative value by -1): LO = most-negative value (0x80000000), HI = 0.
- While busy:
  - start is ignored (no queueing).
  - hi_we/lo_we are ignored.
  - rs_data, rt_data and op may change freely without affecting the result.
- hi/lo hold their values between writes. During busy they show the previous result; partial results are never exposed.

Decomposition:
- Shared package (mips_pkg): op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum, WIDTH default, and a helper for absolute value / two's-complement negate.
- Single module. The datapath is small enough that no sub-module is warranted. If one is split out, make it md_step, the combinational per-iteration shift-add / subtract-restore step.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done exactly 35 cycles after the start edge; HI = 0xFFFFFFFE, LO = 0x00000001; busy high for exactly 34 cycles.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 7. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0; latency unchanged in both cases.
- Pulse start again and assert hi_we with wr_data = 0x1234 at cycle 10 of a MULTU 3 × 4 → second start and the write are ignored. Result HI = 0, LO = 12; only one done pulse.
- In IDLE: hi_we = 1, lo_we = 1, wr_data = 0xA5A5A5A5 → both registers read 0xA5A5A5A5 next cycle. Then start + lo_we in the same cycle → the write is dropped and the op result wins.
- Drop rst_n asynchronously mid-RUN of DIVU 100 / 7 → hi = lo = 0, busy = done = 0 immediately, without waiting for a clock edge. After release, a new MULTU 6 × 7 gives LO = 42, HI = 0 with normal latency.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - operation encodings and FSM states for the multiply/divide unit
package mips_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// Fixed latency: PREP, WIDTH RUN steps, FIX, independent of op and operands.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state;
  md_op_t             op_q;
  logic [WIDTH-1:0]   rs_q, rt_q, mcand, quo, rem;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [CW-1:0]      cnt;
  logic               neg_q, rneg_q;
  logic               is_div, is_signed;
  logic [WIDTH:0]     add_sum, shifted, diff;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign busy      = (state != S_IDLE);

  // rem never exceeds the divisor, so only the shifted/trial value needs the extra bit.
  always_comb begin
    add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, mcand};
    prod_fix = neg_q ? -prod : prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_MULT;
      rs_q   <= '0;
      rt_q   <= '0;
      mcand  <= '0;
      quo    <= '0;
      rem    <= '0;
      prod   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= md_op_t'(op);
            rs_q  <= rs_data;
            rt_q  <= rt_data;
            state <= S_PREP;
          end else begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
          end
        end
        S_PREP: begin
          mcand  <= cond_neg(rt_q, is_signed & rt_q[WIDTH-1]);
          quo    <= cond_neg(rs_q, is_signed & rs_q[WIDTH-1]);
          prod   <= {{WIDTH{1'b0}}, cond_neg(rs_q, is_signed & rs_q[WIDTH-1])};
          rem    <= '0;
          neg_q  <= is_signed & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
          rneg_q <= is_signed & rs_q[WIDTH-1];
          cnt    <= CW'(WIDTH - 1);
          state  <= S_RUN;
        end
        S_RUN: begin
          if (is_div) begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod <= {add_sum, prod[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            if (rt_q == '0) begin
              hi <= rs_q;
              lo <= '1;
            end else begin
              hi <= cond_neg(rem, rneg_q);
              lo <= cond_neg(quo, neg_q);
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done pulse, expected none outstanding");
        end else begin
          mon_e = exp_q.pop_front();
          chk({mon_e.name, " hi"}, hi, mon_e.hi);
          chk({mon_e.name, " lo"}, lo, mon_e.lo);
          chk({mon_e.name, " latency"}, 32'(cyc - mon_e.cyc), 32'd35);
          chk({mon_e.name, " busy_cycles"}, 32'(busy_cnt), 32'd34);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic lw);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    lo_we   = lw;
    wr_data = 32'hDEADBEEF;
    e.name = name;
    e.hi   = eh;
    e.lo   = el;
    e.cyc  = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    lo_we   = 1'b0;
    op      = 2'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: %0d results outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;

    issue("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_done("multu_max");
    issue("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    wait_done("mult_m3x5");
    issue("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done("div_m7d2");
    issue("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done("divu_100d7");
    issue("divu_7d0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b0);
    wait_done("divu_7d0");
    issue("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    wait_done("div_ovf");

    // Second start and MTHI while busy must both be ignored.
    issue("multu_3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1; hi_we = 1'b1; wr_data = 32'h1234; op = 2'b01; rs_data = 32'd5; rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("busy_hi_hold", hi, 32'h0);
    chk("busy_lo_hold", lo, 32'h80000000);
    chk("busy_still", {31'b0, busy}, 32'd1);
    wait_done("multu_3x4");
    repeat (40) @(negedge clk);
    chk("no_second_op", {31'b0, busy}, 32'd0);

    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi", hi, 32'hA5A5A5A5);
    chk("mtlo", lo, 32'hA5A5A5A5);
    issue("multu_2x3_lowe", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
    chk("lo_we_dropped", lo, 32'hA5A5A5A5);
    wait_done("multu_2x3_lowe");

    // Asynchronous reset mid-RUN, checked before any further clock edge.
    issue("divu_reset", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst hi", hi, 32'h0);
    chk("async_rst lo", lo, 32'h0);
    chk("async_rst busy", {31'b0, busy}, 32'd0);
    chk("async_rst done", {31'b0, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    wait_done("multu_6x7");
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
